seg7_frame_decoder: RTL and testbench

SEG7_FRAME_DECODER -- requirements
Module: seg7_frame_decoder

---
 rtl/seg7_frame_decoder_if.sv | 9 +
 rtl/seg7_frame_decoder.sv | 178 +++++++++++++++++
 tb/tb_seg7_frame_decoder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_frame_decoder_if.sv
// Digit strobe bus from a multiplexed seven-segment display scanner.
interface seg7_frame_decoder_if;
    logic [6:0] seg_n;
    logic [3:0] dig_idx;
    logic       dig_stb;

    modport master (output seg_n, output dig_idx, output dig_stb);
    modport slave  (input  seg_n, input  dig_idx, input  dig_stb);
endinterface

// File: rtl/seg7_frame_decoder.sv
// Reassembles a 14-digit seven-segment date-time frame, range-checks it and
// publishes the binary fields on acceptance.
module seg7_frame_decoder #(
    parameter int unsigned LEAP_MOD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_frame_decoder_if.slave  bus,
    output logic [5:0]           sec_bin,
    output logic [5:0]           min_bin,
    output logic [4:0]           hour_bin,
    output logic [4:0]           day_bin,
    output logic [3:0]           month_bin,
    output logic [13:0]          year_bin,
    output logic                 frame_ok,
    output logic                 frame_err,
    output logic [1:0]           err_code
);
    typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;

    state_t      state_q, state_d;
    logic [3:0]  exp_q, exp_d;
    logic [3:0]  dig_q [14];
    logic        st_en, upd_d, ok_d, err_d;
    logic [1:0]  code_d;
    logic        pat_ok;
    logic [3:0]  pat_val;
    logic [6:0]  sec_v, min_v, hour_v, day_v, mon_v;
    logic [13:0] year_v;
    logic [4:0]  dim_v;
    logic        in_range;

    // Returns {legal, value}; anything outside the ten digit glyphs is illegal.
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        case (p)
            7'b1000000: return {1'b1, 4'd0};
            7'b1111001: return {1'b1, 4'd1};
            7'b0100100: return {1'b1, 4'd2};
            7'b0110000: return {1'b1, 4'd3};
            7'b0011001: return {1'b1, 4'd4};
            7'b0010010: return {1'b1, 4'd5};
            7'b0000010: return {1'b1, 4'd6};
            7'b1111000: return {1'b1, 4'd7};
            7'b0000000: return {1'b1, 4'd8};
            7'b0010000: return {1'b1, 4'd9};
            default:    return 5'd0;
        endcase
    endfunction

    assign {pat_ok, pat_val} = seg_decode(bus.seg_n);

    always_comb begin
        sec_v  = 7'(dig_q[1]) * 7'd10 + 7'(dig_q[0]);
        min_v  = 7'(dig_q[3]) * 7'd10 + 7'(dig_q[2]);
        hour_v = 7'(dig_q[5]) * 7'd10 + 7'(dig_q[4]);
        day_v  = 7'(dig_q[7]) * 7'd10 + 7'(dig_q[6]);
        mon_v  = 7'(dig_q[9]) * 7'd10 + 7'(dig_q[8]);
        year_v = 14'(dig_q[13]) * 14'd1000 + 14'(dig_q[12]) * 14'd100
               + 14'(dig_q[11]) * 14'd10 + 14'(dig_q[10]);
        case (mon_v)
            7'd2:                    dim_v = ((32'(year_v) % LEAP_MOD) == 32'd0) ? 5'd29 : 5'd28;
            7'd4, 7'd6, 7'd9, 7'd11: dim_v = 5'd30;
            default:                 dim_v = 5'd31;
        endcase
        in_range = (sec_v <= 7'd59) && (min_v <= 7'd59) && (hour_v <= 7'd23)
                && (mon_v >= 7'd1) && (mon_v <= 7'd12)
                && (day_v >= 7'd1) && (day_v <= 7'(dim_v))
                && (year_v <= 14'd9999);
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        st_en   = 1'b0;
        upd_d   = 1'b0;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = err_code;
        unique case (state_q)
            IDLE: begin
                if (bus.dig_stb && bus.dig_idx == 4'd0) begin
                    if (!pat_ok) begin
                        err_d  = 1'b1;
                        code_d = 2'b01;
                    end else begin
                        st_en   = 1'b1;
                        exp_d   = 4'd1;
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (bus.dig_stb) begin
                    if (!pat_ok) begin
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                        state_d = IDLE;
                    end else if (bus.dig_idx == exp_q) begin
                        st_en = 1'b1;
                        if (exp_q == 4'd13) state_d = CHECK;
                        else                exp_d   = exp_q + 4'd1;
                    end else if (bus.dig_idx == 4'd0) begin
                        err_d  = 1'b1;
                        code_d = 2'b10;
                        st_en  = 1'b1;
                        exp_d  = 4'd1;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = 2'b10;
                        state_d = IDLE;
                    end
                end
            end
            CHECK: begin
                if (in_range) begin
                    ok_d  = 1'b1;
                    upd_d = 1'b1;
                end else begin
                    err_d  = 1'b1;
                    code_d = 2'b11;
                end
                state_d = IDLE;
                // A legal digit 0 here opens the next frame; the store still
                // reads the old digits this cycle, so the overlap is safe.
                if (bus.dig_stb && bus.dig_idx == 4'd0 && pat_ok) begin
                    st_en   = 1'b1;
                    exp_d   = 4'd1;
                    state_d = COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            exp_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 14; i++) dig_q[i] <= 4'd0;
        end else if (st_en) begin
            dig_q[bus.dig_idx] <= pat_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
            sec_bin   <= '0;
            min_bin   <= '0;
            hour_bin  <= '0;
            day_bin   <= '0;
            month_bin <= '0;
            year_bin  <= '0;
        end else begin
            frame_ok  <= ok_d;
            frame_err <= err_d;
            err_code  <= code_d;
            if (upd_d) begin
                sec_bin   <= sec_v[5:0];
                min_bin   <= min_v[5:0];
                hour_bin  <= hour_v[4:0];
                day_bin   <= day_v[4:0];
                month_bin <= mon_v[3:0];
                year_bin  <= year_v;
            end
        end
    end
endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Bench for seg7_frame_decoder: table vectors, corner sequences and random
// frames checked against a calendar-rule reference model.
module tb_seg7_frame_decoder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg7_frame_decoder_if bus();

    logic [5:0]  sec_bin, min_bin;
    logic [4:0]  hour_bin, day_bin;
    logic [3:0]  month_bin;
    logic [13:0] year_bin;
    logic        frame_ok, frame_err;
    logic [1:0]  err_code;

    seg7_frame_decoder #(.LEAP_MOD(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .sec_bin(sec_bin), .min_bin(min_bin), .hour_bin(hour_bin),
        .day_bin(day_bin), .month_bin(month_bin), .year_bin(year_bin),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
    );

    typedef struct {
        int s, m, h, d, mo, y;
        bit ok;
    } vec_t;

    vec_t tbl [14];
    int checks = 0;
    int errors = 0;
    int e_sec = 0, e_min = 0, e_hour = 0, e_day = 0, e_mon = 0, e_year = 0;

    always @(negedge clk) begin
        if (rst_n && frame_ok && frame_err) begin
            errors++;
            $display("FAIL both_pulses frame_ok=%0b frame_err=%0b required not both high", frame_ok, frame_err);
        end
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic int digit_of(input int s, m, h, d, mo, y, i);
        case (i)
            0: return s % 10;   1: return s / 10;
            2: return m % 10;   3: return m / 10;
            4: return h % 10;   5: return h / 10;
            6: return d % 10;   7: return d / 10;
            8: return mo % 10;  9: return mo / 10;
            10: return y % 10;  11: return (y / 10) % 10;
            12: return (y / 100) % 10;
            default: return y / 1000;
        endcase
    endfunction

    // Reference calendar rule: plain arithmetic on the decoded fields.
    function automatic bit model_ok(input int s, m, h, d, mo, y);
        int dim;
        if (mo == 2)                                      dim = (y % 4 == 0) ? 29 : 28;
        else if (mo == 4 || mo == 6 || mo == 9 || mo == 11) dim = 30;
        else                                              dim = 31;
        return s <= 59 && m <= 59 && h <= 23 && mo >= 1 && mo <= 12
            && d >= 1 && d <= dim && y <= 9999;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_sec"}, int'(sec_bin), e_sec);
        chk({tag, "_min"}, int'(min_bin), e_min);
        chk({tag, "_hour"}, int'(hour_bin), e_hour);
        chk({tag, "_day"}, int'(day_bin), e_day);
        chk({tag, "_month"}, int'(month_bin), e_mon);
        chk({tag, "_year"}, int'(year_bin), e_year);
    endtask

    // Drives one strobe starting at a falling edge; back-to-back calls give
    // continuous strobes.
    task automatic strobe(input int idx, input logic [6:0] pat);
        bus.dig_stb = 1'b1;
        bus.dig_idx = 4'(idx);
        bus.seg_n   = pat;
        @(negedge clk);
        bus.dig_stb = 1'b0;
    endtask

    task automatic send_digits(input int s, m, h, d, mo, y, first, last);
        for (int i = first; i <= last; i++)
            strobe(i, seg_of(digit_of(s, m, h, d, mo, y, i)));
    endtask

    task automatic finish_frame(input string tag, input bit exp_ok, input int s, m, h, d, mo, y);
        chk({tag, "_lat1_ok"}, int'(frame_ok), 0);
        chk({tag, "_lat1_err"}, int'(frame_err), 0);
        @(negedge clk);
        chk({tag, "_ok"}, int'(frame_ok), int'(exp_ok));
        chk({tag, "_err"}, int'(frame_err), int'(!exp_ok));
        if (!exp_ok) chk({tag, "_code"}, int'(err_code), 3);
        else begin
            e_sec = s; e_min = m; e_hour = h; e_day = d; e_mon = mo; e_year = y;
        end
        chk_outputs(tag);
    endtask

    initial begin
        int errs_seen;
        int s, m, h, d, mo, y;
        tbl[0]  = '{58, 59, 23, 29, 2, 2024, 1'b1};
        tbl[1]  = '{58, 59, 23, 29, 2, 2023, 1'b0};
        tbl[2]  = '{0, 0, 0, 1, 1, 0, 1'b1};
        tbl[3]  = '{60, 0, 0, 1, 1, 2020, 1'b0};
        tbl[4]  = '{0, 60, 0, 1, 1, 2020, 1'b0};
        tbl[5]  = '{0, 0, 24, 1, 1, 2020, 1'b0};
        tbl[6]  = '{45, 30, 12, 31, 12, 9999, 1'b1};
        tbl[7]  = '{0, 0, 0, 31, 4, 2021, 1'b0};
        tbl[8]  = '{0, 0, 0, 30, 4, 2021, 1'b1};
        tbl[9]  = '{0, 0, 0, 0, 5, 2020, 1'b0};
        tbl[10] = '{0, 0, 0, 1, 0, 2020, 1'b0};
        tbl[11] = '{0, 0, 0, 1, 13, 2020, 1'b0};
        tbl[12] = '{0, 0, 0, 29, 2, 1900, 1'b1};
        tbl[13] = '{59, 59, 23, 28, 2, 2023, 1'b1};

        rst_n = 1'b0;
        bus.dig_stb = 1'b0;
        bus.dig_idx = 4'd0;
        bus.seg_n   = 7'h7F;
        repeat (3) @(negedge clk);
        chk("rst_ok", int'(frame_ok), 0);
        chk("rst_err", int'(frame_err), 0);
        chk("rst_code", int'(err_code), 0);
        chk_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            send_digits(tbl[i].s, tbl[i].m, tbl[i].h, tbl[i].d, tbl[i].mo, tbl[i].y, 0, 13);
            finish_frame($sformatf("tbl%0d", i), tbl[i].ok,
                         tbl[i].s, tbl[i].m, tbl[i].h, tbl[i].d, tbl[i].mo, tbl[i].y);
            @(negedge clk);
        end

        // Wrong index mid-frame aborts to idle; a following index 6 is ignored.
        send_digits(10, 20, 5, 15, 6, 2010, 0, 5);
        strobe(7, seg_of(1));
        chk("seq_err", int'(frame_err), 1);
        chk("seq_code", int'(err_code), 2);
        strobe(6, seg_of(1));
        chk("seq_idle_err", int'(frame_err), 0);
        chk("seq_idle_ok", int'(frame_ok), 0);
        @(negedge clk);
        chk("seq_idle2_ok", int'(frame_ok), 0);
        chk_outputs("seq_idle");

        // Blank glyph at digit 3.
        send_digits(10, 20, 5, 15, 6, 2010, 0, 2);
        strobe(3, 7'b1111111);
        chk("pat_err", int'(frame_err), 1);
        chk("pat_code", int'(err_code), 1);
        @(negedge clk);

        // Restart at index 0 mid-frame: one sequence error, then the new frame.
        send_digits(10, 20, 5, 15, 6, 2010, 0, 9);
        strobe(0, seg_of(digit_of(7, 8, 9, 10, 11, 2012, 0)));
        chk("restart_err", int'(frame_err), 1);
        chk("restart_code", int'(err_code), 2);
        errs_seen = 0;
        for (int i = 1; i <= 13; i++) begin
            strobe(i, seg_of(digit_of(7, 8, 9, 10, 11, 2012, i)));
            errs_seen += int'(frame_err);
        end
        chk("restart_extra_err", errs_seen, 0);
        finish_frame("restart", 1'b1, 7, 8, 9, 10, 11, 2012);
        @(negedge clk);

        // Next frame's digit 0 lands during CHECK of the previous one.
        send_digits(1, 2, 3, 4, 5, 2006, 0, 13);
        strobe(0, seg_of(digit_of(11, 12, 13, 14, 7, 2016, 0)));
        chk("overlap_ok", int'(frame_ok), 1);
        e_sec = 1; e_min = 2; e_hour = 3; e_day = 4; e_mon = 5; e_year = 2006;
        chk_outputs("overlap_a");
        send_digits(11, 12, 13, 14, 7, 2016, 1, 13);
        finish_frame("overlap_b", 1'b1, 11, 12, 13, 14, 7, 2016);
        @(negedge clk);

        // Reset after digit 8 discards the partial frame.
        send_digits(5, 6, 7, 8, 9, 2019, 0, 8);
        rst_n = 1'b0;
        e_sec = 0; e_min = 0; e_hour = 0; e_day = 0; e_mon = 0; e_year = 0;
        @(negedge clk);
        chk("rstmid_code", int'(err_code), 0);
        chk_outputs("rstmid");
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_nopulse", int'(frame_ok | frame_err), 0);
        end
        chk_outputs("rstmid_rel");
        send_digits(9, 8, 7, 6, 5, 2004, 0, 13);
        finish_frame("rstmid_new", 1'b1, 9, 8, 7, 6, 5, 2004);
        @(negedge clk);

        // Reset while the frame sits in CHECK.
        send_digits(1, 1, 1, 1, 1, 2001, 0, 13);
        rst_n = 1'b0;
        e_sec = 0; e_min = 0; e_hour = 0; e_day = 0; e_mon = 0; e_year = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rstchk_nopulse", int'(frame_ok | frame_err), 0);
        end
        chk_outputs("rstchk");

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                s = $urandom_range(0, 59);  m = $urandom_range(0, 59);
                h = $urandom_range(0, 23);  d = $urandom_range(1, 31);
                mo = $urandom_range(1, 12);
            end else begin
                s = $urandom_range(0, 99);  m = $urandom_range(0, 99);
                h = $urandom_range(0, 30);  d = $urandom_range(0, 35);
                mo = $urandom_range(0, 15);
            end
            y = $urandom_range(0, 9999);
            send_digits(s, m, h, d, mo, y, 0, 13);
            finish_frame($sformatf("rnd%0d", k), model_ok(s, m, h, d, mo, y), s, m, h, d, mo, y);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
